// File: rtl/nes_pad_reader_pkg.sv
// configPackage: FSM state encoding and default NES pad timing constants.
package configPackage;
    localparam int LATCH_CYC_DEF = 258;
    localparam int HALF_CYC_DEF  = 129;
    localparam int POLL_CYC_DEF  = 357955;
    typedef enum logic [2:0] {IDLE, LATCH, CLK_LO, CLK_HI, DONE} state_t;
endpackage

// File: rtl/nes_pad_reader_sync.sv
// pad_sync: two-flop synchronizer for the pad serial line, resets to the idle-high level.
module pad_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end
    assign o_q = r_sync;
endmodule

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls an NES pad's 4021 shift register and publishes two-poll-deglitched buttons.
module nes_pad_reader
    import configPackage::*;
#(
    parameter int LATCH_CYC = LATCH_CYC_DEF,
    parameter int HALF_CYC  = HALF_CYC_DEF,
    parameter int POLL_CYC  = POLL_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        joy_strb,
    output logic        joy_clk,
    input  logic        joy_data,
    output logic [11:0] buttons,
    output logic        valid
);
    localparam logic [18:0] POLL_LAST  = 19'(POLL_CYC - 1);
    localparam logic [8:0]  LATCH_LAST = 9'(LATCH_CYC - 1);
    localparam logic [8:0]  HALF_LAST  = 9'(HALF_CYC - 1);

    state_t      r_state;
    state_t      w_next;
    logic [18:0] r_poll;
    logic [8:0]  r_ph;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_prev;
    logic [7:0]  r_btn;
    logic        r_valid;
    logic        r_strb;
    logic        r_jclk;
    logic        w_data;
    logic        w_sample;
    logic        w_done;

    pad_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (joy_data),
        .o_q   (w_data)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (r_poll == POLL_LAST) ? LATCH : IDLE;
            LATCH:   w_next = (r_ph == LATCH_LAST) ? CLK_LO : LATCH;
            CLK_LO:  w_next = (r_ph == HALF_LAST) ? CLK_HI : CLK_LO;
            CLK_HI:  w_next = (r_ph != HALF_LAST) ? CLK_HI : (r_idx == 3'd7) ? DONE : CLK_LO;
            default: w_next = IDLE;
        endcase
        w_sample = (r_state == CLK_LO) && (r_ph == HALF_LAST);
        w_done   = (r_state == CLK_HI) && (w_next == DONE);
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_poll  <= POLL_LAST;
            r_ph    <= 9'd0;
            r_idx   <= 3'd0;
            r_shift <= 8'd0;
            r_prev  <= 8'd0;
            r_btn   <= 8'd0;
            r_valid <= 1'b0;
            r_strb  <= 1'b0;
            r_jclk  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_poll  <= (r_state == IDLE && w_next == LATCH) ? 19'd0 :
                       (r_poll == POLL_LAST) ? r_poll : r_poll + 19'd1;
            r_ph    <= (r_state == IDLE || w_next != r_state) ? 9'd0 : r_ph + 9'd1;
            r_idx   <= (r_state == LATCH) ? 3'd0 :
                       (r_state == CLK_HI && w_next == CLK_LO) ? r_idx + 3'd1 : r_idx;
            if (w_sample)
                r_shift[r_idx] <= ~w_data;
            r_valid <= w_done && (r_shift == r_prev);
            if (w_done) begin
                r_prev <= r_shift;
                if (r_shift == r_prev)
                    r_btn <= r_shift;
            end
            r_strb  <= (w_next == LATCH);
            r_jclk  <= (w_next != CLK_LO);
        end
    end

    assign joy_strb = r_strb;
    assign joy_clk  = r_jclk;
    assign buttons  = {4'b0000, r_btn};
    assign valid    = r_valid;
endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: randomized polls against a 4021 pad model and a poll-level deglitch reference.
module tb_nes_pad_reader;
    localparam int LATCH = 6;
    localparam int HALF  = 4;
    localparam int POLL  = 120;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        joy_data;
    logic        joy_strb;
    logic        joy_clk;
    logic        valid;
    logic [11:0] buttons;

    int checks = 0;
    int errors = 0;
    int vcnt = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    nes_pad_reader #(.LATCH_CYC(LATCH), .HALF_CYC(HALF), .POLL_CYC(POLL)) dut (
        .clk      (clk),
        .reset    (reset),
        .joy_strb (joy_strb),
        .joy_clk  (joy_clk),
        .joy_data (joy_data),
        .buttons  (buttons),
        .valid    (valid)
    );

    // 4021 pad: loads while latched, shifts on joy_clk rising, fills with 1s
    logic [7:0] pressed = 8'h00;
    logic [7:0] sr = 8'hFF;
    logic       pjc = 1'b1;
    always @(posedge clk) begin
        if (joy_strb)
            sr <= ~pressed;
        else if (joy_clk && !pjc)
            sr <= {1'b1, sr[7:1]};
        pjc <= joy_clk;
    end
    assign joy_data = sr[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (valid) vcnt++;

    // Waveform monitor
    logic mon_en = 1'b0;
    logic p_strb = 1'b0;
    logic p_jclk = 1'b1;
    logic have_latch = 1'b0;
    int   last_latch = 0;
    int   srun = 0;
    int   lrun = 0;
    int   hrun = 0;
    int   lo_cnt = 0;
    always @(negedge clk) begin
        cyc++;
        if (!mon_en) begin
            have_latch = 1'b0;
            srun = 0;
            lrun = 0;
            hrun = 0;
            lo_cnt = 0;
        end else begin
            chk("strb_clk_overlap", {31'd0, joy_strb & ~joy_clk}, 32'd0);
            if (joy_strb && !p_strb) begin
                if (have_latch) begin
                    chk("latch_period", cyc - last_latch, POLL);
                    chk("clk_pulses", lo_cnt, 8);
                end
                have_latch = 1'b1;
                last_latch = cyc;
                lo_cnt = 0;
            end
            if (joy_strb) srun++;
            else if (p_strb) begin
                chk("strb_width", srun, LATCH);
                srun = 0;
            end
            if (!joy_clk) begin
                if (p_jclk && lo_cnt > 0) chk("clk_hi_width", hrun, HALF);
                lrun++;
            end else if (!p_jclk) begin
                chk("clk_lo_width", lrun, HALF);
                lrun = 0;
                lo_cnt++;
            end
            hrun = joy_clk ? (p_jclk ? hrun + 1 : 1) : 0;
        end
        p_strb = joy_strb;
        p_jclk = joy_clk;
    end

    // Reference: a poll commits only when its sample repeats the previous poll's sample
    logic [7:0] m_prev = 8'h00;
    logic [7:0] m_btn = 8'h00;

    task automatic start_poll(input logic [7:0] p);
        int n;
        pressed = p;
        for (n = 0; n < 2 * POLL && !joy_strb; n++) @(negedge clk);
        chk("latch_seen", {31'd0, joy_strb}, 32'd1);
    endtask

    task automatic finish_poll(input logic [7:0] s);
        int  v0;
        logic ev;
        v0 = vcnt;
        repeat (LATCH + 16 * HALF + 8) @(negedge clk);
        ev = (s == m_prev);
        if (ev) m_btn = s;
        m_prev = s;
        chk("buttons", {20'd0, buttons}, {24'd0, m_btn});
        chk("valid_pulses", vcnt - v0, {31'd0, ev});
    endtask

    task automatic poll(input logic [7:0] p);
        start_poll(p);
        finish_poll(p);
    endtask

    initial begin
        logic [7:0] last;
        logic [7:0] p;
        int n;
        int falls;
        repeat (4) @(negedge clk);
        chk("rst_strb", {31'd0, joy_strb}, 32'd0);
        chk("rst_jclk", {31'd0, joy_clk}, 32'd1);
        chk("rst_buttons", {20'd0, buttons}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        pressed = 8'h09;
        #1;
        mon_en = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("first_latch_after_reset", {31'd0, joy_strb}, 32'd1);
        @(negedge clk);
        finish_poll(8'h09);
        poll(8'h09);
        for (int i = 0; i < 3; i++) poll(8'h00);
        poll(8'h80);
        poll(8'h00);
        poll(8'h01);
        poll(8'h01);
        poll(8'h02);
        poll(8'h02);
        last = 8'h02;
        for (int i = 0; i < 14; i++) begin
            p = ($urandom_range(0, 1) == 1) ? last : 8'($urandom);
            poll(p);
            last = p;
        end
        poll(8'h5A);
        poll(8'h5A);
        start_poll(8'h5A);
        falls = 0;
        for (n = 0; n < 4 * POLL && falls < 5; n++) begin
            @(negedge clk);
            if (!joy_clk && p_jclk) falls++;
        end
        chk("bit4_reached", falls, 5);
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_strb", {31'd0, joy_strb}, 32'd0);
        chk("abort_jclk", {31'd0, joy_clk}, 32'd1);
        chk("abort_buttons", {20'd0, buttons}, 32'd0);
        chk("abort_valid", {31'd0, valid}, 32'd0);
        repeat (3) @(negedge clk);
        pressed = 8'h33;
        m_prev = 8'h00;
        m_btn = 8'h00;
        #1;
        mon_en = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("latch_after_release", {31'd0, joy_strb}, 32'd1);
        @(negedge clk);
        finish_poll(8'h33);
        poll(8'h33);
        poll(8'h33);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
